// File: rtl/mem_stage.sv
// Memory stage of the pipelined RISC-V core.
// Performs word loads/stores over a req/ack data bus, stalls upstream while an
// access is outstanding, selects the write-back value and drives MEM/WB.
//
// Bus handshake: dbus_req_o, dbus_we_o, dbus_addr_o and dbus_wdata_o are
// registered and held stable from the request cycle through the ack (or
// timeout) cycle inclusive; dbus_ack_i is a single-cycle completion strobe and
// dbus_rdata_i is only meaningful while dbus_ack_i is high. An ack seen while
// no access is outstanding is ignored. After completion req is low for at
// least one cycle before the next request.
module mem_stage #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        PIP_write_mem_i,
    input  logic        PIP_read_mem_i,
    input  logic [31:0] PIP_alu_result_i,
    input  logic [31:0] PIP_second_operand_i,
    input  logic        PIP_use_mem_i,
    input  logic        PIP_write_reg_i,
    input  logic [4:0]  PIP_rd_i,
    output logic        dbus_req_o,
    output logic        dbus_we_o,
    output logic [31:0] dbus_addr_o,
    output logic [31:0] dbus_wdata_o,
    input  logic        dbus_ack_i,
    input  logic [31:0] dbus_rdata_i,
    output logic        stall_o,
    output logic [31:0] EX_MEM_operand_o,
    output logic        PIP_write_reg_o,
    output logic [4:0]  PIP_rd_o,
    output logic [31:0] PIP_wb_data_o,
    output logic        misaligned_o,
    output logic        bus_error_o,
    output logic        dbg_state_o
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    // Counter value of the last bus-wait cycle before the access is abandoned.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t      state_q, state_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        wreg_q, wreg_d;
    logic [4:0]  rd_q, rd_d;
    logic [31:0] wb_q, wb_d;
    logic        mis_q, mis_d;
    logic        berr_q, berr_d;

    logic access;
    logic aligned;

    assign access  = PIP_read_mem_i | PIP_write_mem_i;
    assign aligned = (PIP_alu_result_i[1:0] == 2'b00);

    // Next-state, bus register, MEM/WB and stall logic; MEM/WB defaults to a bubble.
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        wreg_d  = 1'b0;
        rd_d    = 5'd0;
        wb_d    = 32'd0;
        mis_d   = 1'b0;
        berr_d  = 1'b0;
        stall_o = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!access) begin
                    wreg_d = PIP_write_reg_i;
                    rd_d   = PIP_rd_i;
                    wb_d   = PIP_alu_result_i;
                end else if (!aligned) begin
                    mis_d = 1'b1;
                end else begin
                    stall_o = 1'b1;
                    req_d   = 1'b1;
                    // A set write_mem makes the access a store even if read_mem is also set.
                    we_d    = PIP_write_mem_i;
                    addr_d  = {PIP_alu_result_i[31:2], 2'b00};
                    wdata_d = PIP_second_operand_i;
                    cnt_d   = 8'd0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (dbus_ack_i) begin
                    // Ack wins even on the final timeout cycle.
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    addr_d  = 32'd0;
                    wdata_d = 32'd0;
                    state_d = S_IDLE;
                    wreg_d  = PIP_write_reg_i;
                    rd_d    = PIP_rd_i;
                    wb_d    = PIP_use_mem_i ? dbus_rdata_i : PIP_alu_result_i;
                end else if (cnt_q == CNT_LAST) begin
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    addr_d  = 32'd0;
                    wdata_d = 32'd0;
                    state_d = S_IDLE;
                    berr_d  = 1'b1;
                end else begin
                    stall_o = 1'b1;
                    cnt_d   = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            cnt_q   <= 8'd0;
            wreg_q  <= 1'b0;
            rd_q    <= 5'd0;
            wb_q    <= 32'd0;
            mis_q   <= 1'b0;
            berr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            wreg_q  <= wreg_d;
            rd_q    <= rd_d;
            wb_q    <= wb_d;
            mis_q   <= mis_d;
            berr_q  <= berr_d;
        end
    end

    assign dbus_req_o       = req_q;
    assign dbus_we_o        = we_q;
    assign dbus_addr_o      = addr_q;
    assign dbus_wdata_o     = wdata_q;
    assign EX_MEM_operand_o = PIP_alu_result_i;
    assign PIP_write_reg_o  = wreg_q;
    assign PIP_rd_o         = rd_q;
    assign PIP_wb_data_o    = wb_q;
    assign misaligned_o     = mis_q;
    assign bus_error_o      = berr_q;
    assign dbg_state_o      = (state_q == S_WAIT);

endmodule
